// File: rtl/sram_pkg.sv
// sram_pkg: shared FSM state type, strobe levels and default geometry for the SRAM controller.
package sram_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;
  localparam logic STROBE_ON = 1'b0;
  localparam logic STROBE_OFF = 1'b1;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_RAM_DEPTH = 256;
  localparam int DEF_WAIT_CYCLES = 2;
endpackage

// File: rtl/sram_if.sv
// sram_if: request/response and clear-sequence handshake between a sequencer and sram_controller.
interface sram_if
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic [ADDR_WIDTH-1:0] req_address;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic init_start;
  logic init_busy;
  logic init_done;
  modport master (
    output req_valid, req_write, req_address, req_wdata, init_start,
    input req_ready, rsp_valid, rsp_rdata, init_busy, init_done
  );
  modport slave (
    input req_valid, req_write, req_address, req_wdata, init_start,
    output req_ready, rsp_valid, rsp_rdata, init_busy, init_done
  );
endinterface

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: loadable down-counter timing the ACCESS dwell; tc_o flags the last cycle.
module sram_wait_counter #(
  parameter int WIDTH = 2
) (
  input logic clock,
  input logic reset_n,
  input logic load_i,
  input logic [WIDTH-1:0] load_value_i,
  input logic enable_i,
  output logic tc_o
);
  logic [WIDTH-1:0] count_q, count_d;
  always_comb count_d = load_i ? load_value_i : (enable_i && count_q != '0) ? count_q - WIDTH'(1) : count_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else count_q <= count_d;
  end
  assign tc_o = count_q == '0;
endmodule

// File: rtl/sram_controller.sv
// sram_controller: turns valid/ready requests into sequenced async-SRAM strobe cycles,
// and can zero-fill the whole array with chained write cycles.
module sram_controller
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RAM_DEPTH = DEF_RAM_DEPTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input logic clock,
  input logic reset_n,
  sram_if.slave bus,
  output logic [ADDR_WIDTH-1:0] sram_address,
  inout wire [DATA_WIDTH-1:0] sram_data,
  output logic sram_chip_enable,
  output logic sram_write_enable,
  output logic sram_output_enable
);
  localparam int CW = $clog2(WAIT_CYCLES) + 1;
  state_t state_q, state_d;
  logic write_q, write_d, busy_q, busy_d, drive_q, drive_d;
  logic ready_q, ready_d, rsp_valid_q, rsp_valid_d, done_q, done_d;
  logic ce_q, ce_d, we_q, we_d, oe_q, oe_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, init_addr_q, init_addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic start_init, accept, last_init, tc;
  // A clear request outranks a coincident access request.
  assign start_init = state_q == IDLE && bus.init_start;
  assign accept = state_q == IDLE && ready_q && bus.req_valid && !bus.init_start;
  assign last_init = init_addr_q == ADDR_WIDTH'(RAM_DEPTH - 1);
  sram_wait_counter #(.WIDTH(CW)) u_wait (
    .clock,
    .reset_n,
    .load_i(state_q == SETUP),
    .load_value_i(CW'(WAIT_CYCLES - 1)),
    .enable_i(state_q == ACCESS),
    .tc_o(tc)
  );
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    busy_d = busy_q;
    init_addr_d = init_addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    addr_d = addr_q;
    case (state_q)
      IDLE: begin
        if (start_init) begin
          state_d = SETUP;
          busy_d = 1'b1;
          init_addr_d = '0;
          write_d = 1'b1;
          wdata_d = '0;
          addr_d = '0;
        end else if (accept) begin
          state_d = SETUP;
          write_d = bus.req_write;
          wdata_d = bus.req_wdata;
          addr_d = bus.req_address;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: state_d = tc ? HOLD : ACCESS;
      HOLD: begin
        if (busy_q && !last_init) begin
          state_d = SETUP;
          init_addr_d = init_addr_q + ADDR_WIDTH'(1);
          addr_d = init_addr_q + ADDR_WIDTH'(1);
        end else begin
          state_d = IDLE;
          busy_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // Outputs are decoded from the next state so every pin is a flop aligned with its state.
  always_comb begin
    ce_d = (state_d == SETUP || state_d == ACCESS) ? STROBE_ON : STROBE_OFF;
    we_d = (state_d == ACCESS && write_d) ? STROBE_ON : STROBE_OFF;
    oe_d = ((state_d == SETUP || state_d == ACCESS) && !write_d) ? STROBE_ON : STROBE_OFF;
    drive_d = state_d != IDLE && write_d;
    ready_d = state_d == IDLE && !busy_d;
    rsp_valid_d = state_d == HOLD && !write_d;
    done_d = busy_q && !busy_d;
    rdata_d = (state_q == ACCESS && tc && !write_q) ? sram_data : rdata_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_q <= 1'b0;
      busy_q <= 1'b0;
      drive_q <= 1'b0;
      ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      done_q <= 1'b0;
      ce_q <= STROBE_OFF;
      we_q <= STROBE_OFF;
      oe_q <= STROBE_OFF;
      addr_q <= '0;
      init_addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      write_q <= write_d;
      busy_q <= busy_d;
      drive_q <= drive_d;
      ready_q <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      done_q <= done_d;
      ce_q <= ce_d;
      we_q <= we_d;
      oe_q <= oe_d;
      addr_q <= addr_d;
      init_addr_q <= init_addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  assign sram_data = drive_q ? wdata_q : 'z;
  assign sram_address = addr_q;
  assign sram_chip_enable = ce_q;
  assign sram_write_enable = we_q;
  assign sram_output_enable = oe_q;
  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.init_busy = busy_q;
  assign bus.init_done = done_q;
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed checks of access timing, strobes, back-to-back, clear and reset.
module tb_sram_controller;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;
  sram_if bus ();
  sram_if bus3 ();
  wire [15:0] sram_data, sram_data3;
  logic [7:0] sram_address, sram_address3;
  logic ce, we, oe, ce3, we3, oe3;
  sram_controller dut (
    .clock, .reset_n, .bus(bus), .sram_address, .sram_data,
    .sram_chip_enable(ce), .sram_write_enable(we), .sram_output_enable(oe)
  );
  sram_controller #(.WAIT_CYCLES(3)) dut3 (
    .clock, .reset_n, .bus(bus3), .sram_address(sram_address3), .sram_data(sram_data3),
    .sram_chip_enable(ce3), .sram_write_enable(we3), .sram_output_enable(oe3)
  );
  logic [15:0] mem [256];
  assign sram_data = (!ce && !oe) ? mem[sram_address] : 'z;
  always @(posedge clock) if (!ce && !we) mem[sram_address] <= sram_data;
  logic sel = 1'b0;
  wire m_ce = sel ? ce3 : ce;
  wire m_we = sel ? we3 : we;
  wire m_oe = sel ? oe3 : oe;
  wire m_drv = sel ? dut3.drive_q : dut.drive_q;
  wire m_rv = sel ? bus3.rsp_valid : bus.rsp_valid;
  wire m_rdy = sel ? bus3.req_ready : bus.req_ready;
  wire [15:0] m_rd = sel ? bus3.rsp_rdata : bus.rsp_rdata;
  int n_checks = 0, n_errors = 0;
  int we_lo, ce_lo, oe_lo, drv, bad, rsp_cyc, done_cyc, busy_cnt, acc_n, rsp_n;
  int acc [4];
  logic [15:0] rsp_dat;
  logic busy_seen, take;
  logic [15:0] b2b_data [4] = '{16'hA5C3, 16'h0F0F, 16'h1234, 16'hFFFF};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic w, input logic [7:0] a, input logic [15:0] d);
    if (sel) {bus3.req_valid, bus3.req_write, bus3.req_address, bus3.req_wdata} = {v, w, a, d};
    else {bus.req_valid, bus.req_write, bus.req_address, bus.req_wdata} = {v, w, a, d};
  endtask
  // Presents one request at a negedge where ready is high and profiles the access cycle by cycle.
  task automatic run_req(input logic w, input logic [7:0] a, input logic [15:0] d, input int init_at);
    drive(1'b1, w, a, d);
    we_lo = 0; ce_lo = 0; oe_lo = 0; drv = 0; bad = 0; rsp_cyc = 0; done_cyc = 0;
    rsp_dat = '0; busy_seen = 1'b0;
    for (int c = 1; c <= 15 && done_cyc == 0; c++) begin
      @(negedge clock);
      if (c == 1) drive(1'b0, w, a, d);
      bus.init_start = (c == init_at);
      if (m_rv) begin rsp_cyc = c; rsp_dat = m_rd; end
      if (!m_we) we_lo++;
      if (!m_ce) ce_lo++;
      if (!m_oe) oe_lo++;
      if (m_drv) drv++;
      if ((m_drv && !m_oe) || (!m_we && !m_oe)) bad++;
      busy_seen |= bus.init_busy;
      if (m_rdy) done_cyc = c;
    end
    bus.init_start = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.init_start = 1'b0; bus3.init_start = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 16'h0000);
    sel = 1'b1; drive(1'b0, 1'b0, 8'h00, 16'h0000); sel = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_strobes", {ce, we, oe}, 3'b111);
    check("reset_ready", bus.req_ready, 0);
    check("reset_rsp", {bus.rsp_valid, bus.rsp_rdata}, 0);
    check("reset_init", {bus.init_busy, bus.init_done}, 0);
    check("reset_addr", sram_address, 0);
    check("reset_drive", dut.drive_q, 0);
    reset_n = 1'b1;
    @(negedge clock);
    check("ready_after_reset", bus.req_ready, 1);
    run_req(1'b1, 8'h7C, 16'hB7F8, 0);
    check("wr_we_cycles", we_lo, 2);
    check("wr_drive_cycles", drv, 4);
    check("wr_invariant", bad, 0);
    check("wr_done_cycle", done_cyc, 5);
    run_req(1'b0, 8'h7C, 16'h0000, 0);
    check("rd_latency", rsp_cyc, 4);
    check("rd_data", rsp_dat, 16'hB7F8);
    check("rd_oe_cycles", oe_lo, 3);
    check("rd_drive_cycles", drv, 0);
    check("rd_invariant", bad, 0);
    check("rd_done_cycle", done_cyc, 5);
    for (int i = 0; i < 4; i++) run_req(1'b1, 8'(32'h20 + i), b2b_data[i], 0);
    drive(1'b1, 1'b0, 8'h20, 16'h0000);
    acc_n = 0; rsp_n = 0;
    for (int c = 0; c < 60 && rsp_n < 4; c++) begin
      take = bus.req_ready && bus.req_valid;
      @(negedge clock);
      if (take) begin
        acc[acc_n] = c;
        acc_n++;
        drive(acc_n < 4, 1'b0, 8'(32'h20 + acc_n), 16'h0000);
      end
      if (bus.rsp_valid) begin
        check($sformatf("b2b_rsp%0d", rsp_n), bus.rsp_rdata, b2b_data[rsp_n]);
        rsp_n++;
      end
    end
    check("b2b_rsp_count", rsp_n, 4);
    for (int i = 1; i < 4; i++) check($sformatf("b2b_spacing%0d", i), acc[i] - acc[i-1], 5);
    @(negedge clock);
    check("b2b_ready_back", bus.req_ready, 1);
    run_req(1'b1, 8'hF2, 16'h0078, 0);
    bus.init_start = 1'b1;
    drive(1'b1, 1'b0, 8'hF2, 16'h0000);
    @(negedge clock);
    bus.init_start = 1'b0;
    drive(1'b0, 1'b0, 8'hF2, 16'h0000);
    check("init_busy_rise", bus.init_busy, 1);
    check("init_refused_ready", bus.req_ready, 0);
    check("init_first_setup", {ce, we, oe}, 3'b011);
    busy_cnt = 1;
    for (int g = 0; g < 1100 && bus.init_busy; g++) begin
      @(negedge clock);
      if (bus.init_busy) busy_cnt++;
    end
    check("init_busy_cycles", busy_cnt, 1024);
    check("init_done_pulse", bus.init_done, 1);
    check("init_ready_back", bus.req_ready, 1);
    check("init_last_addr", sram_address, 8'hFF);
    @(negedge clock);
    check("init_done_single", bus.init_done, 0);
    run_req(1'b0, 8'hF2, 16'h0000, 0);
    check("init_cleared_F2", rsp_dat, 16'h0000);
    check("init_cleared_F2_rsp", rsp_cyc, 4);
    run_req(1'b0, 8'h7C, 16'h0000, 0);
    check("init_cleared_7C", rsp_dat, 16'h0000);
    drive(1'b1, 1'b1, 8'h55, 16'h1234);
    @(negedge clock);
    drive(1'b0, 1'b1, 8'h55, 16'h1234);
    @(negedge clock);
    check("rst_pre_we", we, 0);
    #1 reset_n = 1'b0;
    #1;
    check("rst_strobes", {ce, we, oe}, 3'b111);
    check("rst_bus_released", dut.drive_q, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_ready_next_edge", bus.req_ready, 1);
    run_req(1'b1, 8'h41, 16'hCAFE, 0);
    run_req(1'b0, 8'h41, 16'h0000, 0);
    check("rst_read_after", rsp_dat, 16'hCAFE);
    run_req(1'b0, 8'h41, 16'h0000, 2);
    check("init_ignored_data", rsp_dat, 16'hCAFE);
    check("init_ignored_busy", busy_seen, 0);
    check("init_ignored_done", done_cyc, 5);
    sel = 1'b1;
    run_req(1'b1, 8'h30, 16'h5A5A, 0);
    check("w3_we_cycles", we_lo, 3);
    check("w3_ce_cycles", ce_lo, 4);
    check("w3_drive_cycles", drv, 5);
    check("w3_wr_invariant", bad, 0);
    check("w3_wr_done", done_cyc, 6);
    run_req(1'b0, 8'h30, 16'h0000, 0);
    check("w3_oe_cycles", oe_lo, 4);
    check("w3_rd_drive", drv, 0);
    check("w3_rd_invariant", bad, 0);
    check("w3_rd_latency", rsp_cyc, 5);
    sel = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
